// File: rtl/conv2d_sched_pkg.sv
// conv2d_sched_pkg: state encoding and default widths shared by the conv2d job scheduler files.
package conv2d_sched_pkg;
  localparam int IDX_W_DEF = 8;
  localparam int CNT_W_DEF = 32;
  typedef enum logic [1:0] {IDLE, START, WAIT_DONE, FINISH} sched_state_e;
endpackage

// File: rtl/conv2d_sched_lat_counter.sv
// conv2d_sched_lat_counter: saturating per-invocation latency counter with last/max capture.
module conv2d_sched_lat_counter import conv2d_sched_pkg::*; #(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             ap_clk,
  input  logic             ap_rst_n,
  input  logic             clr,
  input  logic             active,
  input  logic             stop,
  output logic [CNT_W-1:0] last_lat,
  output logic [CNT_W-1:0] max_lat
);
  logic [CNT_W-1:0] cur, inc;
  assign inc = &cur ? cur : cur + 1'b1;
  // The stop cycle itself is part of the latency, hence capturing inc rather than cur.
  always_ff @(posedge ap_clk or negedge ap_rst_n)
    if (!ap_rst_n) begin
      cur      <= '0;
      last_lat <= '0;
      max_lat  <= '0;
    end else if (clr) begin
      cur      <= '0;
      last_lat <= '0;
      max_lat  <= '0;
    end else if (stop) begin
      cur      <= '0;
      last_lat <= inc;
      if (inc > max_lat) max_lat <= inc;
    end else if (active) cur <= inc;
endmodule

// File: rtl/conv2d_job_scheduler.sv
// conv2d_job_scheduler: runs the conv2d ap_ctrl_hs core over a range of output channels per command.
// Define CONV2D_SCHED_PERF_EN to build the per-invocation latency counter.
module conv2d_job_scheduler import conv2d_sched_pkg::*; #(
  parameter int IDX_W = IDX_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             ap_clk,
  input  logic             ap_rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [IDX_W-1:0] cmd_first,
  input  logic [IDX_W-1:0] cmd_count,
  input  logic             abort,
  output logic             core_start,
  input  logic             core_ready,
  input  logic             core_done,
  output logic [IDX_W-1:0] core_oc,
  output logic             busy,
  output logic             job_done,
  output logic             job_aborted,
  output logic [IDX_W-1:0] inv_done_cnt,
  output logic [CNT_W-1:0] last_lat,
  output logic [CNT_W-1:0] max_lat
);
  sched_state_e state, state_nxt;
  logic [IDX_W-1:0] remaining;
  logic abort_flg, accept, inv_end, abort_eff;
  assign accept    = state == IDLE && cmd_valid;
  // A done seen together with ready in START closes the invocation just like in WAIT_DONE.
  assign inv_end   = core_done && (state == WAIT_DONE || (state == START && core_ready));
  assign abort_eff = abort_flg || abort;
  always_comb begin
    state_nxt   = accept ? (cmd_count == '0 ? FINISH : START)
                : inv_end ? ((remaining == IDX_W'(1) || abort_eff) ? FINISH : START)
                : (state == START && core_ready) ? WAIT_DONE
                : state == FINISH ? IDLE : state;
    cmd_ready   = state == IDLE;
    core_start  = state == START;
    busy        = state != IDLE;
    job_done    = state == FINISH && !abort_flg;
    job_aborted = state == FINISH && abort_flg;
  end
  always_ff @(posedge ap_clk or negedge ap_rst_n)
    if (!ap_rst_n) begin
      state        <= IDLE;
      core_oc      <= '0;
      remaining    <= '0;
      inv_done_cnt <= '0;
      abort_flg    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        core_oc      <= cmd_first;
        remaining    <= cmd_count;
        inv_done_cnt <= '0;
        abort_flg    <= 1'b0;
      end else begin
        if (busy && abort) abort_flg <= 1'b1;
        if (inv_end) begin
          core_oc      <= core_oc + 1'b1;
          remaining    <= remaining - 1'b1;
          inv_done_cnt <= inv_done_cnt + 1'b1;
        end
      end
    end
`ifdef CONV2D_SCHED_PERF_EN
  conv2d_sched_lat_counter #(.CNT_W(CNT_W)) u_lat (
    .ap_clk   (ap_clk),
    .ap_rst_n (ap_rst_n),
    .clr      (accept),
    .active   (state == START || state == WAIT_DONE),
    .stop     (inv_end),
    .last_lat (last_lat),
    .max_lat  (max_lat)
  );
`else
  assign last_lat = '0;
  assign max_lat  = '0;
`endif
endmodule

// File: tb/tb_conv2d_job_scheduler.sv
// tb_conv2d_job_scheduler: directed table plus randomized jobs against a job-level reference model.
module tb_conv2d_job_scheduler;
  logic ap_clk = 1'b0, ap_rst_n = 1'b0, cmd_valid = 1'b0, abort = 1'b0;
  logic core_ready = 1'b0, core_done = 1'b0;
  logic [7:0] cmd_first = '0, cmd_count = '0;
  logic cmd_ready, core_start, busy, job_done, job_aborted;
  logic [7:0] core_oc, inv_done_cnt;
  logic [31:0] last_lat, max_lat;
  int checks = 0, errors = 0;
  int rd = 1, dd = 1, abort_inv = 0, inv_n = 0;
  logic [7:0] oc_q[$];

  always #5 ap_clk = ~ap_clk;

  conv2d_job_scheduler dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_first(cmd_first), .cmd_count(cmd_count), .abort(abort), .core_start(core_start),
    .core_ready(core_ready), .core_done(core_done), .core_oc(core_oc), .busy(busy),
    .job_done(job_done), .job_aborted(job_aborted), .inv_done_cnt(inv_done_cnt),
    .last_lat(last_lat), .max_lat(max_lat)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Core model: ready rd cycles and done dd cycles after the first start cycle of an invocation.
  initial begin : core_model
    bit in_flight;
    int t;
    logic [7:0] oc_start;
    in_flight = 0;
    t = 0;
    oc_start = '0;
    forever begin
      @(posedge ap_clk);
      #1;
      core_ready = 1'b0;
      core_done  = 1'b0;
      abort      = 1'b0;
      if (!ap_rst_n) begin
        in_flight = 0;
        continue;
      end
      if (!in_flight && core_start) begin
        in_flight = 1;
        t = 0;
        inv_n++;
        oc_start = core_oc;
        oc_q.push_back(core_oc);
        if (inv_n == abort_inv) abort = 1'b1;
      end
      if (in_flight) begin
        core_ready = (t == rd);
        core_done  = (t == dd);
        if (t == dd) begin
          chk("oc_stable", core_oc, oc_start);
          in_flight = 0;
        end
        t++;
      end
    end
  end

  task automatic run_job(input logic [7:0] f, input logic [7:0] c, input int r, input int d,
                         input int ab, input int exp_n, input int exp_abt, input int exp_cyc,
                         input int exp_lat);
    int cyc;
    logic [7:0] exp_oc;
    rd = r;
    dd = d;
    abort_inv = ab;
    inv_n = 0;
    oc_q.delete();
    @(negedge ap_clk);
    chk("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_first = f;
    cmd_count = c;
    @(posedge ap_clk);
    #1;
    cmd_valid = 1'b0;
    chk("start_after_accept", core_start, c != 0);
    chk("busy_after_accept", busy, 1);
    cyc = 1;
    while (!(job_done || job_aborted) && cyc < 2000) begin
      @(posedge ap_clk);
      #1;
      cyc++;
    end
    chk("job_cycles", cyc, exp_cyc);
    chk("job_aborted", job_aborted, exp_abt);
    chk("job_done", job_done, exp_abt == 0);
    chk("inv_done_cnt", inv_done_cnt, exp_n);
    chk("invocations", oc_q.size(), exp_n);
    for (int i = 0; i < oc_q.size() && i < exp_n; i++) begin
      exp_oc = f + 8'(i);
      chk("core_oc_seq", oc_q[i], exp_oc);
    end
`ifdef CONV2D_SCHED_PERF_EN
    chk("last_lat", last_lat, exp_lat);
    chk("max_lat", max_lat, exp_lat);
`else
    chk("last_lat", last_lat, 0);
    chk("max_lat", max_lat, 0);
`endif
    @(posedge ap_clk);
    #1;
    chk("pulse_cleared", job_done | job_aborted, 0);
    chk("cmd_ready_after", cmd_ready, 1);
  endtask

  typedef struct {
    logic [7:0] f, c;
    int r, d, ab, n, abt, cyc, lat;
  } vec_t;

  initial begin
    vec_t tbl[5];
    logic [7:0] f, c;
    int r, d, ab, n, abt;
    tbl[0] = '{f: 8'h03, c: 8'd4, r: 1, d: 10, ab: 0, n: 4, abt: 0, cyc: 45, lat: 11};
    tbl[1] = '{f: 8'h10, c: 8'd0, r: 1, d: 10, ab: 0, n: 0, abt: 0, cyc: 1,  lat: 0};
    tbl[2] = '{f: 8'hFE, c: 8'd3, r: 1, d: 2,  ab: 0, n: 3, abt: 0, cyc: 10, lat: 3};
    tbl[3] = '{f: 8'h07, c: 8'd3, r: 0, d: 0,  ab: 0, n: 3, abt: 0, cyc: 4,  lat: 1};
    tbl[4] = '{f: 8'h20, c: 8'd5, r: 2, d: 5,  ab: 2, n: 2, abt: 1, cyc: 13, lat: 6};

    repeat (2) @(posedge ap_clk);
    #1;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_core_start", core_start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pulses", job_done | job_aborted, 0);
    chk("rst_core_oc", core_oc, 0);
    chk("rst_inv_done_cnt", inv_done_cnt, 0);
    chk("rst_lat", last_lat | max_lat, 0);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;

    for (int i = 0; i < 5; i++)
      run_job(tbl[i].f, tbl[i].c, tbl[i].r, tbl[i].d, tbl[i].ab, tbl[i].n, tbl[i].abt,
              tbl[i].cyc, tbl[i].lat);

    // Abort request while idle must not affect the next job.
    @(negedge ap_clk);
    force abort = 1'b1;
    @(negedge ap_clk);
    release abort;
    run_job(8'h55, 8'd2, 1, 3, 0, 2, 0, 9, 4);

    // Reset during the second invocation's WAIT_DONE.
    rd = 1;
    dd = 8;
    abort_inv = 0;
    inv_n = 0;
    oc_q.delete();
    @(negedge ap_clk);
    cmd_valid = 1'b1;
    cmd_first = 8'h40;
    cmd_count = 8'd5;
    @(posedge ap_clk);
    #1;
    cmd_valid = 1'b0;
    repeat (12) @(posedge ap_clk);
    #1;
    chk("mid_busy", busy, 1);
    chk("mid_inv_done_cnt", inv_done_cnt, 1);
    chk("mid_core_oc", core_oc, 8'h41);
    #1;
    ap_rst_n = 1'b0;
    #1;
    chk("async_core_start", core_start, 0);
    chk("async_busy", busy, 0);
    chk("async_cmd_ready", cmd_ready, 1);
    chk("async_core_oc", core_oc, 0);
    chk("async_inv_done_cnt", inv_done_cnt, 0);
    chk("async_lat", last_lat | max_lat, 0);
    repeat (2) @(posedge ap_clk);
    #1;
    chk("rst_no_pulse", job_done | job_aborted, 0);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    run_job(8'h03, 8'd4, 1, 10, 0, 4, 0, 45, 11);

    // Random jobs: expectations from job-level rules, not from the controller's states.
    for (int k = 0; k < 30; k++) begin
      f  = 8'($urandom);
      c  = 8'($urandom_range(0, 6));
      r  = $urandom_range(0, 3);
      d  = r + $urandom_range(0, 6);
      ab = $urandom_range(0, 1) ? $urandom_range(1, c + 1) : 0;
      abt = (ab != 0 && ab <= c) ? 1 : 0;
      n   = abt ? ab : c;
      run_job(f, c, r, d, ab, n, abt, n * (d + 1) + 1, n ? d + 1 : 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
